scoreboard: RTL and testbench

- Register scoreboard for the dual-issue RV32I pipeline.
- Tracks in-flight writers per architectural register.
- Produces busy_vec and load_pending_vec for the issue unit.
- Entries are set by issued slot0/slot1 writers and released by the two writeback ports; the pipeline flush clears all of them.

---
 rtl/scoreboard_pkg.sv | 17 +
 rtl/scoreboard_sb_entry.sv | 79 +++++++
 rtl/scoreboard.sv | 80 ++++++++
 tb/tb_scoreboard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
package scoreboard_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned SB_CNT_W      = 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    // Per-register event counts for one cycle; each field ranges 0..2.
    typedef struct packed {
        logic [1:0] inc;
        logic [1:0] dec;
        logic [1:0] linc;
        logic [1:0] ldec;
    } sb_evt_t;

endpackage

// File: rtl/scoreboard_sb_entry.sv
// One scoreboard entry: saturating writer and load counters for a single register.
// Macro SB_WB_BYPASS_EN makes busy/load_pend drop in the cycle of the final release.
module scoreboard_sb_entry
    import scoreboard_pkg::*;
#(
    parameter int unsigned CntW = SB_CNT_W
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  sb_evt_t evt_i,
    output logic    busy_o,
    output logic    load_pend_o,
    output logic    sat_o,
    output logic    err_o
);

    localparam int unsigned SumW = CntW + 2;
    localparam logic [SumW-1:0] MaxW = SumW'((1 << CntW) - 1);

    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic [CntW-1:0] lcnt_q, lcnt_d;
    logic            werr, lerr;

    // Returns {err, next}: net update clamped to [0, max].
    function automatic logic [CntW:0] cnt_upd(input logic [CntW-1:0] cnt,
                                              input logic [1:0]      inc,
                                              input logic [1:0]      dec);
        logic [SumW-1:0] sum;
        sum = SumW'(cnt) + SumW'(inc);
        if (SumW'(dec) > sum) begin
            return {1'b1, {CntW{1'b0}}};
        end
        sum = sum - SumW'(dec);
        if (sum > MaxW) begin
            return {1'b1, MaxW[CntW-1:0]};
        end
        return {1'b0, sum[CntW-1:0]};
    endfunction

    always_comb begin
        {werr, wcnt_d} = cnt_upd(wcnt_q, evt_i.inc, evt_i.dec);
        {lerr, lcnt_d} = cnt_upd(lcnt_q, evt_i.linc, evt_i.ldec);
        if (flush_i) begin
            wcnt_d = '0;
            lcnt_d = '0;
            werr   = 1'b0;
            lerr   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
            lcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign err_o = werr | lerr;
    assign sat_o = (wcnt_q == MaxW[CntW-1:0]);

`ifdef SB_WB_BYPASS_EN
    logic wdrop, ldrop;

    // Only pure releases draining the counter bypass; issues still take a cycle.
    assign wdrop = !flush_i && (evt_i.inc == 2'd0) && (evt_i.dec != 2'd0) && (wcnt_d == '0);
    assign ldrop = !flush_i && (evt_i.linc == 2'd0) && (evt_i.ldec != 2'd0) && (lcnt_d == '0);

    assign busy_o      = (wcnt_q != '0) && !wdrop;
    assign load_pend_o = (lcnt_q != '0) && !ldrop;
`else
    assign busy_o      = (wcnt_q != '0);
    assign load_pend_o = (lcnt_q != '0);
`endif

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard for the dual-issue RV32I pipeline: decodes issue/writeback
// events per register and collects sticky errors. Optional macro: SB_WB_BYPASS_EN.
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter int unsigned CNT_W    = SB_CNT_W,
    localparam int unsigned RegW    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                iss0_valid,
    input  logic [RegW-1:0]     iss0_rd,
    input  logic                iss0_is_load,
    input  logic                iss1_valid,
    input  logic [RegW-1:0]     iss1_rd,
    input  logic                iss1_is_load,
    input  logic                wb0_valid,
    input  logic [RegW-1:0]     wb0_rd,
    input  logic                wb0_is_load,
    input  logic                wb1_valid,
    input  logic [RegW-1:0]     wb1_rd,
    input  logic                wb1_is_load,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [NUM_REGS-1:0] load_pending_vec,
    output logic [NUM_REGS-1:0] sat_vec,
    output logic                sb_err
);

    logic [NUM_REGS-1:0] err_vec;
    logic                sb_err_q, sb_err_d;

    // x0 is never tracked.
    assign busy_vec[0]         = 1'b0;
    assign load_pending_vec[0] = 1'b0;
    assign sat_vec[0]          = 1'b0;
    assign err_vec[0]          = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        logic    i0, i1, w0, w1;
        sb_evt_t evt;

        assign i0 = iss0_valid && (iss0_rd == RegW'(r));
        assign i1 = iss1_valid && (iss1_rd == RegW'(r));
        assign w0 = wb0_valid  && (wb0_rd  == RegW'(r));
        assign w1 = wb1_valid  && (wb1_rd  == RegW'(r));

        assign evt.inc  = {1'b0, i0} + {1'b0, i1};
        assign evt.dec  = {1'b0, w0} + {1'b0, w1};
        assign evt.linc = {1'b0, i0 && iss0_is_load} + {1'b0, i1 && iss1_is_load};
        assign evt.ldec = {1'b0, w0 && wb0_is_load} + {1'b0, w1 && wb1_is_load};

        scoreboard_sb_entry #(
            .CntW (CNT_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush),
            .evt_i       (evt),
            .busy_o      (busy_vec[r]),
            .load_pend_o (load_pending_vec[r]),
            .sat_o       (sat_vec[r]),
            .err_o       (err_vec[r])
        );
    end

    assign sb_err_d = sb_err_q | (|err_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the register scoreboard.
module tb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        iss0_valid, iss0_is_load, iss1_valid, iss1_is_load;
    logic        wb0_valid, wb0_is_load, wb1_valid, wb1_is_load;
    logic [4:0]  iss0_rd, iss1_rd, wb0_rd, wb1_rd;
    logic [31:0] busy_vec, load_pending_vec, sat_vec;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    scoreboard dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .iss0_valid       (iss0_valid),
        .iss0_rd          (iss0_rd),
        .iss0_is_load     (iss0_is_load),
        .iss1_valid       (iss1_valid),
        .iss1_rd          (iss1_rd),
        .iss1_is_load     (iss1_is_load),
        .wb0_valid        (wb0_valid),
        .wb0_rd           (wb0_rd),
        .wb0_is_load      (wb0_is_load),
        .wb1_valid        (wb1_valid),
        .wb1_rd           (wb1_rd),
        .wb1_is_load      (wb1_is_load),
        .busy_vec         (busy_vec),
        .load_pending_vec (load_pending_vec),
        .sat_vec          (sat_vec),
        .sb_err           (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] eb, input logic [31:0] el,
                           input logic [31:0] es, input logic ee);
        chk({tag, ".busy"}, busy_vec, eb);
        chk({tag, ".load"}, load_pending_vec, el);
        chk({tag, ".sat"}, sat_vec, es);
        chk({tag, ".err"}, {31'd0, sb_err}, {31'd0, ee});
    endtask

    task automatic idle_inputs();
        flush = 0;
        iss0_valid = 0; iss0_rd = 0; iss0_is_load = 0;
        iss1_valid = 0; iss1_rd = 0; iss1_is_load = 0;
        wb0_valid  = 0; wb0_rd  = 0; wb0_is_load  = 0;
        wb1_valid  = 0; wb1_rd  = 0; wb1_is_load  = 0;
    endtask

    // Apply currently driven inputs for one edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 0;
        tick();
        chk_all("idle", 32'h0, 32'h0, 32'h0, 1'b0);

        // 1: single ALU writer to x5
        iss0_valid = 1; iss0_rd = 5;
        tick();
        chk_all("iss5", 32'h20, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1; wb0_rd = 5;
        tick();
        chk_all("wb5", 32'h0, 32'h0, 32'h0, 1'b0);

        // 2: load + ALU writer to x3 in the same cycle
        iss0_valid = 1; iss0_rd = 3; iss0_is_load = 1;
        iss1_valid = 1; iss1_rd = 3;
        tick();
        chk_all("iss3x2", 32'h8, 32'h8, 32'h0, 1'b0);
        wb0_valid = 1; wb0_rd = 3; wb0_is_load = 1;
        tick();
        chk_all("wb3load", 32'h8, 32'h0, 32'h0, 1'b0);
        wb1_valid = 1; wb1_rd = 3;
        tick();
        chk_all("wb3alu", 32'h0, 32'h0, 32'h0, 1'b0);

        // 3: simultaneous issue and release nets to zero change
        iss0_valid = 1; iss0_rd = 7;
        tick();
        chk("iss7", busy_vec, 32'h80);
        iss0_valid = 1; iss0_rd = 7;
        wb0_valid = 1; wb0_rd = 7;
        tick();
        chk("iss7wb7", busy_vec, 32'h80);
        wb0_valid = 1; wb0_rd = 7;
        #1;
`ifdef SB_WB_BYPASS_EN
        chk("wb7same", busy_vec, 32'h0);
`else
        chk("wb7same", busy_vec, 32'h80);
`endif
        tick();
        chk_all("wb7", 32'h0, 32'h0, 32'h0, 1'b0);

        // 4: saturation at 3 writers, then overflow
        iss0_valid = 1; iss0_rd = 9;
        tick();
        iss0_valid = 1; iss0_rd = 9;
        tick();
        chk_all("iss9x2", 32'h200, 32'h0, 32'h0, 1'b0);
        iss0_valid = 1; iss0_rd = 9;
        tick();
        chk_all("iss9x3", 32'h200, 32'h0, 32'h200, 1'b0);
        iss0_valid = 1; iss0_rd = 9;
        tick();
        chk_all("iss9ovf", 32'h200, 32'h0, 32'h200, 1'b1);
        flush = 1;
        tick();
        chk_all("flush_sticky", 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("sticky2", {31'd0, sb_err}, 32'd1);

        // 5: writer underflow, x0 ignored, load underflow
        do_reset();
        chk_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1; wb0_rd = 4;
        tick();
        chk_all("wb4unf", 32'h0, 32'h0, 32'h0, 1'b1);
        do_reset();
        iss0_valid = 1; iss0_rd = 0; iss0_is_load = 1;
        iss1_valid = 1; iss1_rd = 0;
        tick();
        chk_all("x0", 32'h0, 32'h0, 32'h0, 1'b0);
        iss0_valid = 1; iss0_rd = 6;
        tick();
        chk_all("iss6", 32'h40, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1; wb0_rd = 6; wb0_is_load = 1;
        tick();
        chk_all("lunf6", 32'h0, 32'h0, 32'h0, 1'b1);

        // WAW double issue, dual release, and double-issue overflow
        do_reset();
        iss0_valid = 1; iss0_rd = 13; iss1_valid = 1; iss1_rd = 13;
        tick();
        chk_all("waw13", 32'h2000, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1; wb0_rd = 13; wb1_valid = 1; wb1_rd = 13;
        tick();
        chk_all("wb13x2", 32'h0, 32'h0, 32'h0, 1'b0);
        iss0_valid = 1; iss0_rd = 14; iss1_valid = 1; iss1_rd = 14;
        tick();
        iss0_valid = 1; iss0_rd = 14; iss1_valid = 1; iss1_rd = 14;
        tick();
        chk_all("ovf14", 32'h4000, 32'h0, 32'h4000, 1'b1);

        // 6: flush beats same-cycle issue; async reset mid-burst
        do_reset();
        iss0_valid = 1; iss0_rd = 1; iss1_valid = 1; iss1_rd = 2; iss1_is_load = 1;
        tick();
        iss0_valid = 1; iss0_rd = 10;
        tick();
        chk_all("multi", 32'h406, 32'h4, 32'h0, 1'b0);
        flush = 1; iss0_valid = 1; iss0_rd = 2;
        tick();
        chk_all("flush", 32'h0, 32'h0, 32'h0, 1'b0);
        iss0_valid = 1; iss0_rd = 11; iss1_valid = 1; iss1_rd = 12; iss1_is_load = 1;
        tick();
        chk_all("burst", 32'h1800, 32'h1000, 32'h0, 1'b0);
        iss0_valid = 1; iss0_rd = 11;
        wb0_valid = 1; wb0_rd = 4;
        #3;
        rst = 1;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 0;
        tick();
        chk_all("post_rst", 32'h0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
